cond_logic_pred: RTL and testbench
==================================

Name: cond_logic_pred

Overview:
Parametrised successor to the control unit's conditional-logic block.
- Holds NUM_CTX independent NZCV flag contexts, for thread or SPU lanes.
- Evaluates the ARM 4-bit condition against the selected context.
- Adds an IT-style predication window: up to PRED_DEPTH following instructions take their condition from a block header rather than their own Cond field.
- Gates PCSrc, RegWrite and MemWrite between decode and the datapath.

Parameters:
NUM_CTX, 2, number of independent flag contexts (≥1)
PRED_DEPTH, 4, maximum instructions in one predication window (1..8)
CNT_W, 16, width of the optional squash counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
InstrValid  in  1  an instruction is executing this cycle; qualifies all state updates
CtxSel  in  max(1,$clog2(NUM_CTX))  flag context for this instruction
Cond  in  4  instruction condition field
ALUFlags  in  4  {N,Z,C,V} from the ALU
FlagW  in  2  [1]: update N,Z; [0]: update C,V
PCS, RegW, MemW  in  1 each  decoder write requests
RegWSPU  in  1  SPU register write; bypasses the condition
NoWrite  in  1  suppress RegWrite (CMP/TST)
ITStart  in  1  current instruction is a predication header
ITCond  in  4  header base condition
ITMask  in  PRED_DEPTH  bit i=1: slot i uses ITCond; 0: uses ITCond^4'b0001
ITLen  in  $clog2(PRED_DEPTH+1)  slots in the window
PCSrc, RegWrite, MemWrite  out  1 each  gated enables
CondEx  out  1  effective condition passed
Flags  out  4  flags of context CtxSel
ITActive  out  1  predication window open
SquashCnt  out  CNT_W  count of squashed instructions (see Optional Feature)

Behaviour:
Reset
- Reset is asynchronous and active-high on clk.
- All flag contexts clear to 0, the window closes, and slot index and count clear to 0.
- While reset is high, PCSrc, RegWrite, MemWrite and CondEx are 0.
- Reset in the middle of a window aborts the window; no later slot is predicated.

Condition decode (ARM)
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- 1110 and 1111 are always true.

Effective condition
- When ITActive=1 and ITStart=0, the effective condition is ITCond if ITMask[slot]=1, else ITCond^1. Otherwise it is Cond.
- CondEx = decode(effective condition, flags[CtxSel]). It is combinational from the registered flags, so gating has zero latency.

Outputs
- RegWrite = (RegW & CondEx & !NoWrite) | RegWSPU.
- MemWrite = MemW & CondEx.
- PCSrc = PCS & CondEx.
- The three enables are additionally ANDed with InstrValid.

Flag update
- On a clk edge with InstrValid & CondEx, update flags[CtxSel]: {N,Z} when FlagW[1], {C,V} when FlagW[0].
- New flags are visible on Flags the following cycle.
- Other contexts are untouched.

Window FSM (IDLE/ACTIVE)
- IDLE→ACTIVE on InstrValid & ITStart & ITLen≠0. Latch ITCond and ITMask; count = min(ITLen, PRED_DEPTH); slot = 0.
- The header instruction itself is evaluated with its own Cond.
- ITLen=0: header is ignored and the FSM stays IDLE.
- In ACTIVE, each InstrValid & !ITStart consumes one slot: slot++ and count--. On count reaching 1→0 the FSM returns to IDLE after that edge.
- Slots are consumed whether the predicated instruction passes or fails.
- InstrValid=0 holds state (stall).
- ITStart while ACTIVE restarts the window with the new header; the remaining old slots are discarded.
- ITActive = (state==ACTIVE).

Optional Feature:
Macro COND_SQUASH_CNT_EN.
- Defined: SquashCnt counts cycles with InstrValid & !CondEx & (PCS|RegW|MemW). It saturates at 2^CNT_W−1 and clears on reset.
- Undefined: no counter logic is built and SquashCnt is tied to 0.

Test Plan:
1. Reset then ctx0: ALUFlags=4'b0100, FlagW=2'b11, Cond=1110, InstrValid=1 → Flags=0100 next cycle. Then Cond=0000 (EQ) with RegW=1 → RegWrite=1 and CondEx=1; Cond=0001 → RegWrite=0.
2. Context isolation (NUM_CTX=2): set Z in ctx0, leave ctx1 at 0. CtxSel=1 with Cond=EQ and MemW=1 → MemWrite=0; CtxSel=0 → MemWrite=1.
3. Partial update: flags 0000; ALUFlags=1111 with FlagW=2'b01 → Flags=0011. With CondEx=0, FlagW=2'b11 → flags unchanged.
4. Window: ITCond=0000, ITMask=4'b0101, ITLen=3, Z=1, then 3 valid instructions with RegW=1 and Cond=1110 → RegWrite 1,0,1. ITActive drops after the third; a stall cycle mid-window does not consume a slot.
5. Restart and abort: new ITStart at slot 1 re-latches the window (4 new slots). Assert reset mid-window → ITActive=0 immediately, and the next instruction uses its own Cond. RegWSPU=1 with CondEx=0 → RegWrite=1. NoWrite=1 → RegWrite=0.
6. COND_SQUASH_CNT_EN defined, CNT_W=2: 5 failing RegW instructions → SquashCnt=3 (saturated). Undefined → SquashCnt=0.

Source files
------------

// File: rtl/cond_logic_pred_if.sv
// cond_logic_pred_if
//   Bundles the decode-side request lines and the gated enables that
//   cond_logic_pred places between instruction decode and the datapath.
//
//   Modports:
//     master : decoder side, drives requests, observes gated enables
//     slave  : cond_logic_pred itself
//
//   Qualifier semantics: InstrValid marks a cycle that carries a real
//   instruction. Every state update in the block (flags, predication
//   window, squash count) happens only on a clock edge where InstrValid is
//   high; InstrValid low is a stall and leaves all state untouched. There
//   is no back-pressure: the block accepts every valid instruction.
//
//   Signals:
//     InstrValid, CtxSel, Cond, ALUFlags, FlagW   instruction + flag update
//     PCS, RegW, MemW, RegWSPU, NoWrite           decoder write requests
//     ITStart, ITCond, ITMask, ITLen              predication header
//     PCSrc, RegWrite, MemWrite, CondEx           gated enables / condition
//     Flags, ITActive, SquashCnt                  status
interface cond_logic_pred_if #(
    parameter int NUM_CTX    = 2,
    parameter int PRED_DEPTH = 4,
    parameter int CNT_W      = 16
);
    localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam int LEN_W = $clog2(PRED_DEPTH + 1);

    logic                  InstrValid;
    logic [CTX_W-1:0]      CtxSel;
    logic [3:0]            Cond;
    logic [3:0]            ALUFlags;
    logic [1:0]            FlagW;
    logic                  PCS;
    logic                  RegW;
    logic                  MemW;
    logic                  RegWSPU;
    logic                  NoWrite;
    logic                  ITStart;
    logic [3:0]            ITCond;
    logic [PRED_DEPTH-1:0] ITMask;
    logic [LEN_W-1:0]      ITLen;

    logic                  PCSrc;
    logic                  RegWrite;
    logic                  MemWrite;
    logic                  CondEx;
    logic [3:0]            Flags;
    logic                  ITActive;
    logic [CNT_W-1:0]      SquashCnt;

    modport master (
        output InstrValid, CtxSel, Cond, ALUFlags, FlagW,
        output PCS, RegW, MemW, RegWSPU, NoWrite,
        output ITStart, ITCond, ITMask, ITLen,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags, ITActive, SquashCnt
    );

    modport slave (
        input  InstrValid, CtxSel, Cond, ALUFlags, FlagW,
        input  PCS, RegW, MemW, RegWSPU, NoWrite,
        input  ITStart, ITCond, ITMask, ITLen,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags, ITActive, SquashCnt
    );
endinterface

// File: rtl/cond_logic_pred.sv
// cond_logic_pred
//   Conditional-execution unit with NUM_CTX independent NZCV flag contexts
//   and an IT-style predication window of up to PRED_DEPTH slots. Gates
//   PCSrc / RegWrite / MemWrite between decode and the datapath with zero
//   latency (combinational from the registered flags and window state).
//
//   Ports:
//     clk    : clock
//     reset  : asynchronous active-high reset
//     bus    : cond_logic_pred_if.slave (requests in, gated enables out)
//
//   Optional feature: define COND_SQUASH_CNT_EN to build a saturating
//   counter of squashed write/branch requests on SquashCnt; without it
//   SquashCnt is tied to zero.
//
//   The window FSM state is visible directly on bus.ITActive.
module cond_logic_pred #(
    parameter int NUM_CTX    = 2,
    parameter int PRED_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input logic              clk,
    input logic              reset,
    cond_logic_pred_if.slave bus
);
    localparam int CTX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam int LEN_W  = $clog2(PRED_DEPTH + 1);
    localparam int SLOT_W = (PRED_DEPTH > 1) ? $clog2(PRED_DEPTH) : 1;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} win_state_t;

    win_state_t            state;
    logic [3:0]            flags [NUM_CTX];
    logic [3:0]            it_cond;
    logic [PRED_DEPTH-1:0] it_mask;
    logic [SLOT_W-1:0]     slot;
    logic [LEN_W-1:0]      count;

    logic [3:0]            cur_flags;
    logic [3:0]            eff_cond;
    logic                  cond_pass;

    function automatic logic cond_decode(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = cf;
            4'b0011: r = !cf;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = cf & !z;
            4'b1001: r = !cf | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z & (n == v);
            4'b1101: r = z | (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Loop-select rather than direct indexing so a CtxSel value beyond
    // NUM_CTX reads as all-zero flags instead of an out-of-range access.
    always_comb begin
        cur_flags = 4'b0000;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (CTX_W'(i) == bus.CtxSel) cur_flags = flags[i];
        end
    end

    // A header instruction always runs on its own Cond, even mid-window.
    always_comb begin
        eff_cond = bus.Cond;
        if (state == ACTIVE && !bus.ITStart) begin
            eff_cond = it_mask[slot] ? it_cond : (it_cond ^ 4'b0001);
        end
    end

    assign cond_pass = !reset && cond_decode(eff_cond, cur_flags);

    assign bus.CondEx   = cond_pass;
    assign bus.PCSrc    = bus.InstrValid & bus.PCS & cond_pass;
    assign bus.MemWrite = bus.InstrValid & bus.MemW & cond_pass;
    // SPU writes bypass the condition but must still be silent in reset.
    assign bus.RegWrite = bus.InstrValid & !reset &
                          ((bus.RegW & cond_pass & !bus.NoWrite) | bus.RegWSPU);
    assign bus.Flags    = cur_flags;
    assign bus.ITActive = (state == ACTIVE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CTX; i++) flags[i] <= 4'b0000;
        end else if (bus.InstrValid && cond_pass) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                if (CTX_W'(i) == bus.CtxSel) begin
                    if (bus.FlagW[1]) flags[i][3:2] <= bus.ALUFlags[3:2];
                    if (bus.FlagW[0]) flags[i][1:0] <= bus.ALUFlags[1:0];
                end
            end
        end
    end

    // Window FSM. A header with ITLen=0 is ignored in either state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            it_cond <= 4'b0000;
            it_mask <= '0;
            slot    <= '0;
            count   <= '0;
        end else if (bus.InstrValid) begin
            if (bus.ITStart) begin
                if (bus.ITLen != '0) begin
                    state   <= ACTIVE;
                    it_cond <= bus.ITCond;
                    it_mask <= bus.ITMask;
                    slot    <= '0;
                    count   <= (bus.ITLen > LEN_W'(PRED_DEPTH)) ? LEN_W'(PRED_DEPTH) : bus.ITLen;
                end
            end else if (state == ACTIVE) begin
                // Slots are consumed regardless of pass/fail.
                slot  <= slot + 1'b1;
                count <= count - 1'b1;
                if (count == LEN_W'(1)) state <= IDLE;
            end
        end
    end

`ifdef COND_SQUASH_CNT_EN
    logic [CNT_W-1:0] squash_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            squash_cnt <= '0;
        end else if (bus.InstrValid && !cond_pass && (bus.PCS || bus.RegW || bus.MemW)
                     && squash_cnt != {CNT_W{1'b1}}) begin
            squash_cnt <= squash_cnt + 1'b1;
        end
    end

    assign bus.SquashCnt = squash_cnt;
`else
    assign bus.SquashCnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_cond_logic_pred.sv
// tb_cond_logic_pred
//   Self-checking bench for cond_logic_pred. Directed scenarios follow the
//   block's feature list; a randomized run compares every cycle against a
//   behavioural model (flag array, queue of pending window conditions,
//   saturating squash count). Honours COND_SQUASH_CNT_EN when defined.
module tb_cond_logic_pred;
    localparam int NUM_CTX    = 2;
    localparam int PRED_DEPTH = 4;
    localparam int CNT_W      = 2;
    localparam int CTX_W      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam int LEN_W      = $clog2(PRED_DEPTH + 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    cond_logic_pred_if #(.NUM_CTX(NUM_CTX), .PRED_DEPTH(PRED_DEPTH), .CNT_W(CNT_W)) bus ();

    cond_logic_pred #(.NUM_CTX(NUM_CTX), .PRED_DEPTH(PRED_DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [3:0] m_flags [NUM_CTX];
    logic [3:0] exp_q [$];   // conditions of the window slots still to come
    int         m_sq;

    // ARM conditions come in complementary pairs: the odd code inverts the even one.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    function automatic logic [3:0] model_eff();
        return (exp_q.size() != 0 && !bus.ITStart) ? exp_q[0] : bus.Cond;
    endfunction

    function automatic logic [8:0] exp_out();
        logic [3:0] f;
        logic p;
        if (reset) return 9'b0;
        f = m_flags[bus.CtxSel];
        p = ref_cond(model_eff(), f);
        return {bus.InstrValid & bus.PCS & p,
                bus.InstrValid & ((bus.RegW & p & !bus.NoWrite) | bus.RegWSPU),
                bus.InstrValid & bus.MemW & p,
                p, f, exp_q.size() != 0};
    endfunction

    function automatic logic [8:0] obs();
        return {bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.CondEx, bus.Flags, bus.ITActive};
    endfunction

    function automatic int exp_sq();
`ifdef COND_SQUASH_CNT_EN
        return m_sq;
`else
        return 0;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_CTX; i++) m_flags[i] = 4'b0000;
        exp_q.delete();
        m_sq = 0;
    endfunction

    function automatic void model_tick();
        logic p;
        int   n;
        if (reset || !bus.InstrValid) return;
        p = ref_cond(model_eff(), m_flags[bus.CtxSel]);
        if (p && bus.FlagW[1]) m_flags[bus.CtxSel][3:2] = bus.ALUFlags[3:2];
        if (p && bus.FlagW[0]) m_flags[bus.CtxSel][1:0] = bus.ALUFlags[1:0];
        if (!p && (bus.PCS || bus.RegW || bus.MemW) && m_sq < (1 << CNT_W) - 1) m_sq++;
        if (bus.ITStart) begin
            if (bus.ITLen != '0) begin
                exp_q.delete();
                n = (int'(bus.ITLen) > PRED_DEPTH) ? PRED_DEPTH : int'(bus.ITLen);
                for (int i = 0; i < n; i++) exp_q.push_back(bus.ITMask[i] ? bus.ITCond : (bus.ITCond ^ 4'b0001));
            end
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bus.InstrValid = 1'b0; bus.CtxSel = '0;  bus.Cond = 4'b1110;
        bus.ALUFlags = 4'b0;   bus.FlagW = 2'b0; bus.PCS = 1'b0;
        bus.RegW = 1'b0;       bus.MemW = 1'b0;  bus.RegWSPU = 1'b0;
        bus.NoWrite = 1'b0;    bus.ITStart = 1'b0; bus.ITCond = 4'b0;
        bus.ITMask = '0;       bus.ITLen = '0;
    endtask

    task automatic drive(input int ctx, input logic [3:0] cond, input logic [1:0] fw,
                         input logic [3:0] alu, input logic regw, input logic memw);
        clear_inputs();
        bus.InstrValid = 1'b1;
        bus.CtxSel     = CTX_W'(ctx);
        bus.Cond       = cond;
        bus.FlagW      = fw;
        bus.ALUFlags   = alu;
        bus.RegW       = regw;
        bus.MemW       = memw;
    endtask

    // Model advances with the inputs present at the coming edge.
    task automatic cycle();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        model_reset();
        bus.InstrValid = 1'b1; bus.RegW = 1'b1; bus.PCS = 1'b1; bus.MemW = 1'b1; bus.RegWSPU = 1'b1;
        #2;
        total++; if (obs() !== 9'b0) begin bad++; $display("FAIL reset_outputs got=%b exp=%b", obs(), 9'b0); end
        @(posedge clk); #1;
        total++; if (obs() !== 9'b0) begin bad++; $display("FAIL reset_held got=%b exp=%b", obs(), 9'b0); end
        total++; if (bus.SquashCnt !== '0) begin bad++; $display("FAIL reset_squash got=%0d exp=0", bus.SquashCnt); end
        reset = 1'b0;
        #1;
        total++; if (bus.RegWrite !== 1'b1) begin bad++; $display("FAIL reset_release_regw got=%b exp=1", bus.RegWrite); end
        clear_inputs();
    endtask

    task automatic test_cond_basic();
        do_reset();
        drive(0, 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0); #1; cycle();
        clear_inputs(); #1;
        total++; if (bus.Flags !== 4'b0100) begin bad++; $display("FAIL basic_flags got=%b exp=0100", bus.Flags); end
        drive(0, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0); #1;
        total++; if ({bus.RegWrite, bus.CondEx} !== 2'b11) begin bad++; $display("FAIL basic_eq got=%b exp=11", {bus.RegWrite, bus.CondEx}); end
        cycle();
        drive(0, 4'b0001, 2'b00, 4'b0000, 1'b1, 1'b0); #1;
        total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL basic_ne got=%b exp=0", bus.RegWrite); end
        cycle();
    endtask

    task automatic test_ctx_isolation();
        do_reset();
        drive(0, 4'b1110, 2'b10, 4'b0100, 1'b0, 1'b0); #1; cycle();
        drive(1, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1); #1;
        total++; if (bus.MemWrite !== 1'b0) begin bad++; $display("FAIL ctx1_memw got=%b exp=0", bus.MemWrite); end
        total++; if (bus.Flags !== 4'b0000) begin bad++; $display("FAIL ctx1_flags got=%b exp=0000", bus.Flags); end
        drive(0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1); #1;
        total++; if (bus.MemWrite !== 1'b1) begin bad++; $display("FAIL ctx0_memw got=%b exp=1", bus.MemWrite); end
        cycle();
    endtask

    task automatic test_partial_update();
        do_reset();
        drive(0, 4'b1110, 2'b01, 4'b1111, 1'b0, 1'b0); #1; cycle();
        clear_inputs(); #1;
        total++; if (bus.Flags !== 4'b0011) begin bad++; $display("FAIL partial_cv got=%b exp=0011", bus.Flags); end
        drive(0, 4'b0000, 2'b11, 4'b1111, 1'b0, 1'b0); #1;
        total++; if (bus.CondEx !== 1'b0) begin bad++; $display("FAIL partial_condex got=%b exp=0", bus.CondEx); end
        cycle();
        clear_inputs(); #1;
        total++; if (bus.Flags !== 4'b0011) begin bad++; $display("FAIL partial_gated got=%b exp=0011", bus.Flags); end
    endtask

    task automatic test_window();
        logic [2:0] exp_rw;
        exp_rw = 3'b101;
        do_reset();
        drive(0, 4'b1110, 2'b10, 4'b0100, 1'b0, 1'b0); #1; cycle();
        drive(0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0);
        bus.ITStart = 1'b1; bus.ITCond = 4'b0000; bus.ITMask = 4'b0101; bus.ITLen = LEN_W'(3);
        #1;
        total++; if (bus.ITActive !== 1'b0) begin bad++; $display("FAIL win_pre_active got=%b exp=0", bus.ITActive); end
        cycle();
        for (int s = 0; s < 3; s++) begin
            drive(0, 4'b1110, 2'b00, 4'b0000, 1'b1, 1'b0); #1;
            total++; if (bus.RegWrite !== exp_rw[s]) begin bad++; $display("FAIL win_slot%0d got=%b exp=%b", s, bus.RegWrite, exp_rw[s]); end
            total++; if (bus.ITActive !== 1'b1) begin bad++; $display("FAIL win_active%0d got=%b exp=1", s, bus.ITActive); end
            cycle();
            if (s == 0) begin
                clear_inputs(); #1; cycle();
            end
        end
        clear_inputs(); #1;
        total++; if (bus.ITActive !== 1'b0) begin bad++; $display("FAIL win_closed got=%b exp=0", bus.ITActive); end
    endtask

    task automatic test_restart_abort();
        do_reset();
        drive(0, 4'b1110, 2'b10, 4'b0100, 1'b0, 1'b0); #1; cycle();
        drive(0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0);
        bus.ITStart = 1'b1; bus.ITCond = 4'b0001; bus.ITMask = 4'b1111; bus.ITLen = LEN_W'(4);
        #1; cycle();
        drive(0, 4'b1110, 2'b00, 4'b0000, 1'b1, 1'b0); #1;
        total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL restart_old_slot got=%b exp=0", bus.RegWrite); end
        cycle();
        drive(0, 4'b1110, 2'b00, 4'b0000, 1'b1, 1'b0);
        bus.ITStart = 1'b1; bus.ITCond = 4'b0000; bus.ITMask = 4'b1111; bus.ITLen = LEN_W'(4);
        #1;
        total++; if (bus.RegWrite !== 1'b1) begin bad++; $display("FAIL restart_header got=%b exp=1", bus.RegWrite); end
        cycle();
        for (int s = 0; s < 4; s++) begin
            drive(0, 4'b1110, 2'b00, 4'b0000, 1'b1, 1'b0); #1;
            total++; if (bus.RegWrite !== 1'b1) begin bad++; $display("FAIL restart_slot%0d got=%b exp=1", s, bus.RegWrite); end
            cycle();
        end
        clear_inputs(); #1;
        total++; if (bus.ITActive !== 1'b0) begin bad++; $display("FAIL restart_len4_closed got=%b exp=0", bus.ITActive); end
        // open a window of EQ slots, then abort it with reset
        drive(0, 4'b1110, 2'b10, 4'b0100, 1'b0, 1'b0);
        bus.ITStart = 1'b1; bus.ITCond = 4'b0000; bus.ITMask = 4'b1111; bus.ITLen = LEN_W'(4);
        #1; cycle();
        drive(0, 4'b1110, 2'b00, 4'b0000, 1'b1, 1'b0); #1; cycle();
        reset = 1'b1; model_reset(); #1;
        total++; if (bus.ITActive !== 1'b0) begin bad++; $display("FAIL abort_active got=%b exp=0", bus.ITActive); end
        total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL abort_regw got=%b exp=0", bus.RegWrite); end
        reset = 1'b0; #1;
        total++; if (bus.RegWrite !== 1'b1) begin bad++; $display("FAIL abort_own_cond got=%b exp=1", bus.RegWrite); end
        cycle();
        drive(0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0); bus.RegWSPU = 1'b1; #1;
        total++; if ({bus.RegWrite, bus.CondEx} !== 2'b10) begin bad++; $display("FAIL spu_bypass got=%b exp=10", {bus.RegWrite, bus.CondEx}); end
        cycle();
        drive(0, 4'b1110, 2'b00, 4'b0000, 1'b1, 1'b0); bus.NoWrite = 1'b1; #1;
        total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL nowrite got=%b exp=0", bus.RegWrite); end
        cycle();
    endtask

    task automatic test_squash();
        int want;
`ifdef COND_SQUASH_CNT_EN
        want = 3;
`else
        want = 0;
`endif
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(0, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0); #1; cycle();
        end
        total++; if (int'(bus.SquashCnt) !== want) begin bad++; $display("FAIL squash_sat got=%0d exp=%0d", bus.SquashCnt, want); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            clear_inputs();
            bus.InstrValid = ($urandom_range(0, 7) != 0);
            bus.CtxSel     = CTX_W'($urandom_range(0, NUM_CTX - 1));
            bus.Cond       = 4'($urandom_range(0, 15));
            bus.ALUFlags   = 4'($urandom_range(0, 15));
            bus.FlagW      = 2'($urandom_range(0, 3));
            bus.PCS        = 1'($urandom_range(0, 1));
            bus.RegW       = 1'($urandom_range(0, 1));
            bus.MemW       = 1'($urandom_range(0, 1));
            bus.RegWSPU    = ($urandom_range(0, 7) == 0);
            bus.NoWrite    = ($urandom_range(0, 3) == 0);
            bus.ITStart    = ($urandom_range(0, 5) == 0);
            bus.ITCond     = 4'($urandom_range(0, 15));
            bus.ITMask     = PRED_DEPTH'($urandom);
            bus.ITLen      = LEN_W'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1; model_reset(); #1;
                total++; if (obs() !== 9'b0) begin bad++; $display("FAIL rand_reset k=%0d got=%b exp=%b", k, obs(), 9'b0); end
                reset = 1'b0;
            end
            #1;
            total++; if (obs() !== exp_out()) begin bad++; $display("FAIL rand_out k=%0d got=%b exp=%b", k, obs(), exp_out()); end
            total++; if (int'(bus.SquashCnt) !== exp_sq()) begin bad++; $display("FAIL rand_squash k=%0d got=%0d exp=%0d", k, bus.SquashCnt, exp_sq()); end
            cycle();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_cond_basic();
        test_ctx_isolation();
        test_partial_update();
        test_window();
        test_restart_abort();
        test_squash();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
